// File: rtl/prince_round_ctrl.sv
// Round sequencer for the two-share masked PRINCE core.
// Walks whitening, forward/middle/backward rounds and meters mask words.
module prince_round_ctrl #(
    parameter int SBOX_STAGES = 2,
    parameter int NR_HALF     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dec,
    input  logic       rnd_valid,
    output logic       rnd_ack,
    output logic       load_en,
    output logic       sbox_en,
    output logic [1:0] sbox_stage,
    output logic       sbox_inv,
    output logic       lin_en,
    output logic [1:0] lin_mode,
    output logic [3:0] rc_idx,
    output logic       dec_q,
    output logic       busy,
    output logic       done
);

    localparam int RW = $clog2(NR_HALF + 1);
    localparam logic [1:0]    LAST_STAGE = 2'(SBOX_STAGES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR_HALF);
    localparam logic [3:0]    RC_HALF    = 4'(NR_HALF);
    localparam logic [3:0]    RC_FINAL   = 4'(2 * NR_HALF + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, F_SBOX, F_LIN, M_SBOX, M_LIN,
        M_ISBOX, B_LIN, B_ISBOX, FINAL, DONE
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] round_cnt, round_n;
    logic [1:0]    stage_cnt, stage_n;
    logic          dec_n;
    logic          in_sbox, sbox_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= '0;
            stage_cnt <= '0;
            dec_q     <= 1'b0;
        end else begin
            state     <= state_n;
            round_cnt <= round_n;
            stage_cnt <= stage_n;
            dec_q     <= dec_n;
        end
    end

    assign in_sbox = (state == F_SBOX) || (state == M_SBOX) ||
                     (state == M_ISBOX) || (state == B_ISBOX);
    // The layer finishes on the cycle its last stage actually gets a mask word.
    assign sbox_last = in_sbox && rnd_valid && (stage_cnt == LAST_STAGE);

    always_comb begin
        state_n    = state;
        round_n    = round_cnt;
        stage_n    = stage_cnt;
        dec_n      = dec_q;
        rnd_ack    = 1'b0;
        load_en    = 1'b0;
        sbox_en    = 1'b0;
        sbox_stage = 2'd0;
        sbox_inv   = 1'b0;
        lin_en     = 1'b0;
        lin_mode   = 2'd0;
        rc_idx     = 4'd0;
        busy       = (state != IDLE);
        done       = 1'b0;

        if (in_sbox) begin
            sbox_stage = stage_cnt;
            sbox_inv   = (state == M_ISBOX) || (state == B_ISBOX);
            if (rnd_valid) begin
                sbox_en = 1'b1;
                rnd_ack = 1'b1;
                stage_n = sbox_last ? 2'd0 : stage_cnt + 2'd1;
            end
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    dec_n   = dec;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                round_n = RW'(1);
                stage_n = 2'd0;
                state_n = F_SBOX;
            end
            F_SBOX: begin
                if (sbox_last) state_n = F_LIN;
            end
            F_LIN: begin
                lin_en   = 1'b1;
                lin_mode = 2'd0;
                rc_idx   = 4'(round_cnt);
                if (round_cnt < LAST_ROUND) begin
                    round_n = round_cnt + RW'(1);
                    state_n = F_SBOX;
                end else begin
                    state_n = M_SBOX;
                end
            end
            M_SBOX: begin
                if (sbox_last) state_n = M_LIN;
            end
            M_LIN: begin
                lin_en   = 1'b1;
                lin_mode = 2'd1;
                state_n  = M_ISBOX;
            end
            M_ISBOX: begin
                if (sbox_last) begin
                    round_n = RW'(1);
                    state_n = B_LIN;
                end
            end
            B_LIN: begin
                lin_en   = 1'b1;
                lin_mode = 2'd2;
                rc_idx   = RC_HALF + 4'(round_cnt);
                state_n  = B_ISBOX;
            end
            B_ISBOX: begin
                if (sbox_last) begin
                    if (round_cnt < LAST_ROUND) begin
                        round_n = round_cnt + RW'(1);
                        state_n = B_LIN;
                    end else begin
                        state_n = FINAL;
                    end
                end
            end
            FINAL: begin
                lin_en   = 1'b1;
                lin_mode = 2'd3;
                rc_idx   = RC_FINAL;
                state_n  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Directed bench for prince_round_ctrl: default build plus a one-stage S-box build.
module tb_prince_round_ctrl;

    logic clk = 1'b0;
    logic rst, start, dec, rnd_valid;

    logic       rnd_ack, load_en, sbox_en, sbox_inv, lin_en, dec_q, busy, done;
    logic [1:0] sbox_stage, lin_mode;
    logic [3:0] rc_idx;

    logic       rnd_ack1, load_en1, sbox_en1, sbox_inv1, lin_en1, dec_q1, busy1, done1;
    logic [1:0] sbox_stage1, lin_mode1;
    logic [3:0] rc_idx1;

    always #5 clk = ~clk;

    prince_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dec(dec), .rnd_valid(rnd_valid),
        .rnd_ack(rnd_ack), .load_en(load_en), .sbox_en(sbox_en),
        .sbox_stage(sbox_stage), .sbox_inv(sbox_inv), .lin_en(lin_en),
        .lin_mode(lin_mode), .rc_idx(rc_idx), .dec_q(dec_q), .busy(busy),
        .done(done)
    );

    prince_round_ctrl #(.SBOX_STAGES(1), .NR_HALF(5)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dec(dec), .rnd_valid(rnd_valid),
        .rnd_ack(rnd_ack1), .load_en(load_en1), .sbox_en(sbox_en1),
        .sbox_stage(sbox_stage1), .sbox_inv(sbox_inv1), .lin_en(lin_en1),
        .lin_mode(lin_mode1), .rc_idx(rc_idx1), .dec_q(dec_q1), .busy(busy1),
        .done(done1)
    );

    typedef struct packed {
        logic       load_en;
        logic       sbox_en;
        logic       lin_en;
        logic       rnd_ack;
        logic [1:0] stage;
        logic       inv;
        logic [1:0] mode;
        logic [3:0] rc;
        logic       busy;
        logic       done;
        logic       dec_q;
    } smp_t;

    typedef struct {
        int   tst;
        int   cyc;
        logic rv;
        smp_t exp;
    } vec_t;

    smp_t tr [0:127];
    smp_t tr1[0:127];
    vec_t vecs[$];
    logic [10:0] exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    int nsb, nln, nld, ndone, done_a, done_b, load_a, load_b;
    int nbusy, nexcl, nackbad, ninv, first_inv, ndecq, nstage_nz;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic smp_t samp(input int which);
        smp_t s;
        if (which == 1) begin
            s.load_en = load_en1; s.sbox_en = sbox_en1; s.lin_en = lin_en1;
            s.rnd_ack = rnd_ack1; s.stage = sbox_stage1; s.inv = sbox_inv1;
            s.mode = lin_mode1; s.rc = rc_idx1; s.busy = busy1;
            s.done = done1; s.dec_q = dec_q1;
        end else begin
            s.load_en = load_en; s.sbox_en = sbox_en; s.lin_en = lin_en;
            s.rnd_ack = rnd_ack; s.stage = sbox_stage; s.inv = sbox_inv;
            s.mode = lin_mode; s.rc = rc_idx; s.busy = busy;
            s.done = done; s.dec_q = dec_q;
        end
        return s;
    endfunction

    function automatic smp_t get(input int which, input int n);
        return (which == 1) ? tr1[n] : tr[n];
    endfunction

    function automatic smp_t mk(input bit ld, input bit sb, input bit ln,
                                input bit ack, input int st, input bit inv,
                                input int md, input int rc, input bit bz,
                                input bit dn);
        smp_t s;
        s.load_en = ld; s.sbox_en = sb; s.lin_en = ln; s.rnd_ack = ack;
        s.stage = 2'(st); s.inv = inv; s.mode = 2'(md); s.rc = 4'(rc);
        s.busy = bz; s.done = dn; s.dec_q = 1'b0;
        return s;
    endfunction

    function automatic logic [10:0] ev_of(input smp_t s);
        if (s.load_en) return {2'd1, 2'd0, 1'b0, 2'd0, s.rc};
        if (s.sbox_en) return {2'd2, s.stage, s.inv, 2'd0, 4'd0};
        return {2'd3, 2'd0, 1'b0, s.mode, s.rc};
    endfunction

    function automatic logic [10:0] ev_sb(input int st, input bit inv);
        return {2'd2, 2'(st), inv, 2'd0, 4'd0};
    endfunction

    function automatic logic [10:0] ev_ln(input int md, input int rc);
        return {2'd3, 2'd0, 1'b0, 2'(md), 4'(rc)};
    endfunction

    // Reference enable schedule for a run without stalls or aborts.
    task automatic model(input int stages);
        exp_q.delete();
        exp_q.push_back({2'd1, 9'd0});
        for (int r = 1; r <= 5; r++) begin
            for (int s = 0; s < stages; s++) exp_q.push_back(ev_sb(s, 1'b0));
            exp_q.push_back(ev_ln(0, r));
        end
        for (int s = 0; s < stages; s++) exp_q.push_back(ev_sb(s, 1'b0));
        exp_q.push_back(ev_ln(1, 0));
        for (int s = 0; s < stages; s++) exp_q.push_back(ev_sb(s, 1'b1));
        for (int r = 1; r <= 5; r++) begin
            exp_q.push_back(ev_ln(2, 5 + r));
            for (int s = 0; s < stages; s++) exp_q.push_back(ev_sb(s, 1'b1));
        end
        exp_q.push_back(ev_ln(3, 11));
    endtask

    task automatic chk_events(input string nm, input int which, input int hi);
        logic [10:0] got[$];
        int nbad;
        smp_t s;
        for (int n = 1; n <= hi; n++) begin
            s = get(which, n);
            if (s.load_en || s.sbox_en || s.lin_en) got.push_back(ev_of(s));
        end
        chk({nm, " event count"}, got.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) nbad++;
        chk({nm, " event order"}, nbad, 0);
    endtask

    task automatic stats(input int which, input int hi);
        smp_t s;
        nsb = 0; nln = 0; nld = 0; ndone = 0; nbusy = 0; nexcl = 0;
        nackbad = 0; ninv = 0; first_inv = -1; ndecq = 0; nstage_nz = 0;
        done_a = -1; done_b = -1; load_a = -1; load_b = -1;
        for (int n = 1; n <= hi; n++) begin
            s = get(which, n);
            if (s.sbox_en) begin
                if (s.inv) begin
                    if (first_inv < 0) first_inv = nsb;
                    ninv++;
                end
                nsb++;
            end
            if (s.lin_en) nln++;
            if (s.load_en) begin
                if (load_a < 0) load_a = n;
                else if (load_b < 0) load_b = n;
                nld++;
            end
            if (s.done) begin
                if (done_a < 0) done_a = n;
                else if (done_b < 0) done_b = n;
                ndone++;
            end
            if (s.busy) nbusy++;
            if (s.dec_q) ndecq++;
            if (s.stage != 2'd0) nstage_nz++;
            if (32'(s.load_en) + 32'(s.sbox_en) + 32'(s.lin_en) > 1) nexcl++;
            if (s.rnd_ack !== s.sbox_en) nackbad++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; dec = 1'b0; rnd_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle 0 is the cycle whose closing edge samples start; cycle n follows edge n-1.
    task automatic run(input int ncyc, input logic dval, input int st_lo,
                       input int st_hi, input int rst_cyc, input bit hold,
                       input int sp1, input int sp2);
        @(negedge clk);
        start = 1'b1; dec = dval; rnd_valid = 1'b1; rst = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            start     = hold || (n == sp1) || (n == sp2);
            dec       = 1'b0;
            rnd_valid = !(n >= st_lo && n <= st_hi);
            rst       = (n == rst_cyc);
            #1;
            tr[n]  = samp(0);
            tr1[n] = samp(1);
        end
        start = 1'b0; rnd_valid = 1'b1; rst = 1'b0;
    endtask

    task automatic apply_table(input int t);
        foreach (vecs[i]) begin
            if (vecs[i].tst == t) begin
                chk($sformatf("t%0d cycle %0d rnd_valid %0b", t, vecs[i].cyc,
                              vecs[i].rv),
                    32'(tr[vecs[i].cyc]), 32'(vecs[i].exp));
            end
        end
    endtask

    initial begin
        //               ld sb ln ak st iv md rc bz dn
        vecs.push_back('{1, 1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{1, 2, 1'b1, mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{1, 3, 1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{1, 4, 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0)});
        vecs.push_back('{1, 16, 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 5, 1, 0)});
        vecs.push_back('{1, 17, 1'b1, mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{1, 19, 1'b1, mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0)});
        vecs.push_back('{1, 20, 1'b1, mk(0, 1, 0, 1, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{1, 21, 1'b1, mk(0, 1, 0, 1, 1, 1, 0, 0, 1, 0)});
        vecs.push_back('{1, 22, 1'b1, mk(0, 0, 1, 0, 0, 0, 2, 6, 1, 0)});
        vecs.push_back('{1, 34, 1'b1, mk(0, 0, 1, 0, 0, 0, 2, 10, 1, 0)});
        vecs.push_back('{1, 36, 1'b1, mk(0, 1, 0, 1, 1, 1, 0, 0, 1, 0)});
        vecs.push_back('{1, 37, 1'b1, mk(0, 0, 1, 0, 0, 0, 3, 11, 1, 0)});
        vecs.push_back('{1, 38, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
        vecs.push_back('{1, 39, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{2, 8, 1'b1, mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{2, 9, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{2, 10, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{2, 11, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{2, 12, 1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{2, 13, 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 3, 1, 0)});
        vecs.push_back('{2, 40, 1'b1, mk(0, 0, 1, 0, 0, 0, 3, 11, 1, 0)});
        vecs.push_back('{2, 41, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)});

        rst = 1'b1; start = 1'b0; dec = 1'b0; rnd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'(samp(0)), 0);
        chk("reset outputs stages1", 32'(samp(1)), 0);

        // Nominal encrypt, also the one-stage build
        do_reset();
        run(45, 1'b0, -1, -1, -1, 1'b0, -1, -1);
        apply_table(1);
        stats(0, 45);
        chk("t1 sbox_en pulses", nsb, 24);
        chk("t1 lin_en pulses", nln, 12);
        chk("t1 done cycle", done_a, 38);
        chk("t1 done count", ndone, 1);
        chk("t1 busy cycles", nbusy, 38);
        chk("t1 enable overlap", nexcl, 0);
        chk("t1 ack vs sbox_en", nackbad, 0);
        chk("t1 inv pulses", ninv, 12);
        chk("t1 first inv pulse", first_inv, 12);
        model(2);
        chk_events("t1", 0, 45);
        stats(1, 45);
        chk("t6 done cycle", done_a, 26);
        chk("t6 sbox_en pulses", nsb, 12);
        chk("t6 lin_en pulses", nln, 12);
        chk("t6 stage nonzero", nstage_nz, 0);
        chk("t6 enable overlap", nexcl, 0);
        model(1);
        chk_events("t6", 1, 45);

        // Three-cycle mask stall in stage 1 of the third forward S-box layer
        do_reset();
        run(50, 1'b0, 9, 11, -1, 1'b0, -1, -1);
        apply_table(2);
        stats(0, 50);
        chk("t2 done cycle", done_a, 41);
        chk("t2 sbox_en pulses", nsb, 24);
        chk("t2 ack vs sbox_en", nackbad, 0);
        model(2);
        chk_events("t2", 0, 50);

        // Abort mid-operation, then a clean restart
        do_reset();
        run(22, 1'b0, -1, -1, 20, 1'b0, -1, -1);
        chk("t3 cycle 21 outputs", 32'(tr[21]), 0);
        stats(0, 22);
        chk("t3 done after abort", ndone, 0);
        run(45, 1'b0, -1, -1, -1, 1'b0, -1, -1);
        chk("t3 restart load rc", 32'(tr[1]), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        stats(0, 45);
        chk("t3 restart done cycle", done_a, 38);
        model(2);
        chk_events("t3", 0, 45);

        // Starts while busy are ignored
        do_reset();
        run(45, 1'b0, -1, -1, -1, 1'b0, 10, 38);
        stats(0, 45);
        chk("t4 load count", nld, 1);
        chk("t4 done count", ndone, 1);
        chk("t4 done cycle", done_a, 38);

        // Held start chains a second operation
        do_reset();
        run(80, 1'b0, -1, -1, -1, 1'b1, -1, -1);
        stats(0, 80);
        chk("t4 held first load", load_a, 1);
        chk("t4 held second load", load_b, 40);
        chk("t4 held first done", done_a, 38);
        chk("t4 held second done", done_b, 77);

        // Decrypt: dec latched at start only
        do_reset();
        run(45, 1'b1, -1, -1, -1, 1'b0, -1, -1);
        stats(0, 39);
        chk("t5 dec_q high cycles", ndecq, 39);
        chk("t5 done cycle", done_a, 38);
        model(2);
        chk_events("t5", 0, 45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
